ddr_burst_splitter: RTL and testbench

Upstream command adapter that feeds ddr_sdram_ctrl's AXI-like aw/w/b/ar/r channels. It accepts one long linear read or write transfer of up to 4096 beats from a user master. It splits the transfer into controller bursts that never exceed MAX_BEATS and never cross a DDR row boundary. It generates awlen/arlen and wlast, passes data beats straight through in both directions, and signals completion of the whole transfer.

---
 rtl/ddr_burst_splitter.sv | 238 +++++++++++++++++++++++
 tb/tb_ddr_burst_splitter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_splitter.sv
// ddr_burst_splitter
// Turns one long linear read or write transfer (up to 4096 beats) from a user
// master into a sequence of controller bursts. No burst exceeds MAX_BEATS or
// crosses a DDR row. Only one burst is outstanding at a time. Data beats pass
// straight through combinationally in both directions.
//
// Ports
//   core_clk, core_rst          clock / asynchronous active-high reset
//   cmd_valid/ready/wr/addr/len  transfer request (len = beats-1)
//   cmd_done                     one-cycle pulse after the last burst completes
//   busy                         transfer in progress
//   u_w*                         user write stream (valid/ready/data)
//   u_r*                         user read stream; u_rlast = final beat of transfer
//   aw*, w*, b*                  controller write address / data / response
//   ar*, r*                      controller read address / data
module ddr_burst_splitter #(
    parameter int BA_BITS   = 2,
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 10,
    parameter int DQ_LEVEL  = 1,
    parameter int MAX_BEATS = 256,
    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1,
    localparam int DW = 8 << DQ_LEVEL
) (
    input  logic          core_clk,
    input  logic          core_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [11:0]   cmd_len,
    output logic          cmd_done,
    output logic          busy,
    input  logic          u_wvalid,
    output logic          u_wready,
    input  logic [DW-1:0] u_wdata,
    output logic          u_rvalid,
    input  logic          u_rready,
    output logic [DW-1:0] u_rdata,
    output logic          u_rlast,
    output logic          awvalid,
    input  logic          awready,
    output logic [AW-1:0] awaddr,
    output logic [7:0]    awlen,
    output logic          wvalid,
    input  logic          wready,
    output logic          wlast,
    output logic [DW-1:0] wdata,
    input  logic          bvalid,
    output logic          bready,
    output logic          arvalid,
    input  logic          arready,
    output logic [AW-1:0] araddr,
    output logic [7:0]    arlen,
    input  logic          rvalid,
    output logic          rready,
    input  logic          rlast,
    input  logic [DW-1:0] rdata
);

    // Beats per row; the beat index within a row is the address above the
    // byte-in-beat bits and below the row bits.
    localparam int              IDX_BITS  = COL_BITS - 1;
    localparam logic [16:0]     ROW_BEATS = 17'(1 << IDX_BITS);
    localparam logic [16:0]     MAX_B17   = 17'(MAX_BEATS);
    localparam logic [8:0]      MAX_B9    = 9'(MAX_BEATS);
    localparam logic [AW-1:0]   LOW_MASK  = AW'((1 << DQ_LEVEL) - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        R_ADDR,
        R_DATA
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg;
    logic [16:0]   remaining_reg;
    logic [8:0]    burst_reg;
    logic [8:0]    beat_cnt_reg;
    logic          alive_reg;
    logic          done_reg;

    // burst = min(remaining, MAX_BEATS, beats left in the row)
    function automatic logic [8:0] burst_calc(input logic [IDX_BITS-1:0] idx,
                                              input logic [16:0] rem);
        logic [16:0] row_left;
        row_left = ROW_BEATS - 17'(idx);
        if (row_left <= MAX_B17 && row_left <= rem)
            return row_left[8:0];
        else if (MAX_B17 <= rem)
            return MAX_B9;
        else
            return rem[8:0];
    endfunction

    logic          accept;
    logic          w_beat;
    logic          wlast_int;
    logic          w_end;
    logic          b_end;
    logic          r_end;
    logic          last_burst;
    logic [AW-1:0] start_addr;
    logic [16:0]   start_rem;
    logic [AW-1:0] addr_adv;
    logic [16:0]   remaining_adv;

    assign accept        = (state_reg == IDLE) && alive_reg && cmd_valid;
    assign w_beat        = (state_reg == W_DATA) && u_wvalid && wready;
    assign wlast_int     = (beat_cnt_reg == burst_reg - 9'd1);
    assign w_end         = w_beat && wlast_int;
    assign b_end         = (state_reg == W_RESP) && bvalid;
    // The read burst ends on the controller's rlast, not on the local count.
    assign r_end         = (state_reg == R_DATA) && rvalid && u_rready && rlast;
    assign start_addr    = cmd_addr & ~LOW_MASK;
    assign start_rem     = 17'(cmd_len) + 17'd1;
    // Address advance wraps naturally at the top of the AW-bit space.
    assign addr_adv      = addr_reg + (AW'(burst_reg) << DQ_LEVEL);
    assign remaining_adv = remaining_reg - 17'(burst_reg);
    assign last_burst    = (remaining_adv == 17'd0);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            burst_reg     <= '0;
            beat_cnt_reg  <= '0;
            alive_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            // alive_reg keeps cmd_ready low until the first clock after reset.
            alive_reg <= 1'b1;
            done_reg  <= 1'b0;
            if (accept) begin
                addr_reg      <= start_addr;
                remaining_reg <= start_rem;
                burst_reg     <= burst_calc(start_addr[COL_BITS+DQ_LEVEL-2:DQ_LEVEL], start_rem);
            end else if (b_end || r_end) begin
                addr_reg      <= addr_adv;
                remaining_reg <= remaining_adv;
                burst_reg     <= burst_calc(addr_adv[COL_BITS+DQ_LEVEL-2:DQ_LEVEL], remaining_adv);
                done_reg      <= last_burst;
            end
            if (w_end) begin
                beat_cnt_reg <= '0;
            end else if (w_beat) begin
                beat_cnt_reg <= beat_cnt_reg + 9'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        busy       = (state_reg != IDLE);
        cmd_done   = done_reg;
        u_wready   = 1'b0;
        u_rvalid   = 1'b0;
        u_rdata    = '0;
        u_rlast    = 1'b0;
        awvalid    = 1'b0;
        awaddr     = '0;
        awlen      = '0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        wdata      = '0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        araddr     = '0;
        arlen      = '0;
        rready     = 1'b0;

        case (state_reg)
            IDLE: begin
                cmd_ready = alive_reg;
                if (accept) begin
                    state_next = cmd_wr ? W_ADDR : R_ADDR;
                end
            end
            W_ADDR: begin
                awvalid = 1'b1;
                awaddr  = addr_reg;
                awlen   = 8'(burst_reg - 9'd1);
                if (awready) begin
                    state_next = W_DATA;
                end
            end
            W_DATA: begin
                wvalid   = u_wvalid;
                u_wready = wready;
                wdata    = u_wdata;
                wlast    = wlast_int;
                if (w_end) begin
                    state_next = W_RESP;
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = last_burst ? IDLE : W_ADDR;
                end
            end
            R_ADDR: begin
                arvalid = 1'b1;
                araddr  = addr_reg;
                arlen   = 8'(burst_reg - 9'd1);
                if (arready) begin
                    state_next = R_DATA;
                end
            end
            R_DATA: begin
                u_rvalid = rvalid;
                rready   = u_rready;
                u_rdata  = rdata;
                // Only the last beat of the final burst closes the user transfer.
                u_rlast  = rlast && (remaining_reg == 17'(burst_reg));
                if (r_end) begin
                    state_next = last_burst ? IDLE : R_ADDR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr_burst_splitter.sv
`timescale 1ns/1ps
module tb_ddr_burst_splitter;

    localparam int BA_BITS   = 2;
    localparam int ROW_BITS  = 13;
    localparam int COL_BITS  = 10;
    localparam int DQ_LEVEL  = 1;
    localparam int MAX_BEATS = 256;
    localparam int AW        = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1;
    localparam int DW        = 8 << DQ_LEVEL;
    localparam longint BPB        = longint'(1) << DQ_LEVEL;
    localparam longint ROW_BYTES  = longint'(1) << (COL_BITS + DQ_LEVEL - 1);
    localparam longint ADDR_SPACE = longint'(1) << AW;

    logic          core_clk = 1'b0;
    logic          core_rst;
    logic          cmd_valid, cmd_ready, cmd_wr, cmd_done, busy;
    logic [AW-1:0] cmd_addr;
    logic [11:0]   cmd_len;
    logic          u_wvalid, u_wready;
    logic [DW-1:0] u_wdata;
    logic          u_rvalid, u_rready, u_rlast;
    logic [DW-1:0] u_rdata;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid, wready, wlast;
    logic [DW-1:0] wdata;
    logic          bvalid, bready;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid, rready, rlast;
    logic [DW-1:0] rdata;

    always #5 core_clk = ~core_clk;

    ddr_burst_splitter #(
        .BA_BITS(BA_BITS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
        .DQ_LEVEL(DQ_LEVEL), .MAX_BEATS(MAX_BEATS)
    ) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done), .busy(busy),
        .u_wvalid(u_wvalid), .u_wready(u_wready), .u_wdata(u_wdata),
        .u_rvalid(u_rvalid), .u_rready(u_rready), .u_rdata(u_rdata), .u_rlast(u_rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference burst list: walk the byte address with plain arithmetic,
    // cutting at row ends, MAX_BEATS and the remaining count.
    longint m_addr[$];
    int     m_len[$];

    task automatic model_bursts(input longint a0, input int len);
        longint a;
        longint row_end;
        int     rem;
        int     to_row;
        int     b;
        m_addr.delete();
        m_len.delete();
        a   = a0 - (a0 % BPB);
        rem = len + 1;
        while (rem > 0) begin
            row_end = (a / ROW_BYTES + 1) * ROW_BYTES;
            to_row  = int'((row_end - a) / BPB);
            b = rem;
            if (b > MAX_BEATS) b = MAX_BEATS;
            if (b > to_row) b = to_row;
            m_addr.push_back(a);
            m_len.push_back(b);
            a   = (a + longint'(b) * BPB) % ADDR_SPACE;
            rem = rem - b;
        end
    endtask

    function automatic bit coin(input bit stall);
        return stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_len = '0;
        u_wvalid = 0; u_wdata = '0; u_rready = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0;
        rvalid = 0; rlast = 0; rdata = '0;
    endtask

    // Runs one transfer with a controller/user model around the DUT.
    // abort_wbeats > 0 stops mid write data after that many controller beats.
    task automatic run_transfer(input bit wr, input longint addr, input int len,
                                input bit stall, input int abort_wbeats,
                                output int n_b, output int first_len, output int last_len);
        logic [DW-1:0] wq[$];
        logic [DW-1:0] rq[$];
        logic [DW-1:0] r_cur;
        logic [DW-1:0] exp_r;
        logic [AW-1:0] aw_h_addr, ar_h_addr;
        logic [7:0]    aw_h_len, ar_h_len;
        bit  aw_hold, ar_hold, accepted, in_xfer, done_pending, finished, b_pending, aborted;
        int  nexp, total, wi, ws, wb_in_burst, issued, bursts_done;
        int  r_left, ruser, aw_cnt, ar_cnt, cyc, budget;

        model_bursts(addr, len);
        nexp  = m_len.size();
        total = len + 1;
        for (int i = 0; i < total; i++) wq.push_back(DW'($urandom));
        aw_hold = 0; ar_hold = 0; accepted = 0; in_xfer = 0; done_pending = 0;
        finished = 0; b_pending = 0; aborted = 0;
        wi = 0; ws = 0; wb_in_burst = 0; issued = 0; bursts_done = 0;
        r_left = 0; ruser = 0; aw_cnt = 0; ar_cnt = 0; cyc = 0;
        aw_h_addr = '0; ar_h_addr = '0; aw_h_len = '0; ar_h_len = '0;
        r_cur = '0;
        n_b = 0; first_len = -1; last_len = -1;
        budget = 40 * total + 200;
        cmd_wr = wr; cmd_addr = AW'(addr); cmd_len = 12'(len);

        while (!(finished && !done_pending)) begin
            if (cyc >= budget) begin
                checks++; errors++;
                $display("FAIL timeout wr=%0d addr=%0h len=%0d bursts_done=%0d expected=%0d",
                         wr, addr, len, bursts_done, nexp);
                break;
            end
            @(negedge core_clk);
            cyc++;
            cmd_valid = !accepted;
            awready   = coin(stall);
            arready   = coin(stall);
            wready    = coin(stall);
            u_wvalid  = (wi < total) && coin(stall);
            u_wdata   = (wi < total) ? wq[wi] : '0;
            bvalid    = b_pending && coin(stall);
            rvalid    = (r_left > 0) && coin(stall);
            rlast     = (r_left == 1);
            rdata     = r_cur;
            u_rready  = (stall && cyc >= 8 && cyc < 13) ? 1'b0 : coin(stall);
            #1;

            check("cmd_done", cmd_done, done_pending);
            check("cmd_ready", cmd_ready, !in_xfer);
            check("busy", busy, in_xfer);
            check("aw_ar_both", awvalid && arvalid, 0);
            if (aw_hold) begin
                check("aw_hold_valid", awvalid, 1);
                check("aw_hold_addr", awaddr, aw_h_addr);
                check("aw_hold_len", awlen, aw_h_len);
            end
            if (ar_hold) begin
                check("ar_hold_valid", arvalid, 1);
                check("ar_hold_addr", araddr, ar_h_addr);
                check("ar_hold_len", arlen, ar_h_len);
            end
            aw_hold = awvalid && !awready; aw_h_addr = awaddr; aw_h_len = awlen;
            ar_hold = arvalid && !arready; ar_h_addr = araddr; ar_h_len = arlen;
            done_pending = 0;

            if (cmd_valid && cmd_ready) begin
                accepted = 1;
                in_xfer  = 1;
            end
            if ((awvalid && awready) || (arvalid && arready)) begin
                logic [AW-1:0] ba;
                logic [7:0]    bl;
                ba = awvalid ? awaddr : araddr;
                bl = awvalid ? awlen : arlen;
                if (awvalid) aw_cnt++; else ar_cnt++;
                if (issued < nexp) begin
                    check("burst_addr", ba, m_addr[issued]);
                    check("burst_len", bl, m_len[issued] - 1);
                end else begin
                    checks++; errors++;
                    $display("FAIL extra_burst addr=%0h len=%0d required_count=%0d", ba, bl, nexp);
                end
                if (n_b == 0) first_len = int'(bl);
                last_len = int'(bl);
                n_b++;
                issued++;
                wb_in_burst = 0;
                if (arvalid) begin
                    r_left = int'(arlen) + 1;
                    r_cur  = DW'($urandom);
                end
            end
            if (wvalid && wready) begin
                if (ws < total) check("wdata", wdata, wq[ws]);
                else begin
                    checks++; errors++;
                    $display("FAIL extra_wbeat got=%0h required_beats=%0d", wdata, total);
                end
                if (issued > 0 && issued <= nexp)
                    check("wlast", wlast, wb_in_burst == m_len[issued-1] - 1);
                ws++;
                wb_in_burst++;
                if (wlast) b_pending = 1;
            end
            if (u_wvalid && u_wready) wi++;
            if (bvalid && bready) begin
                b_pending = 0;
                bursts_done++;
                if (bursts_done == nexp) begin
                    finished = 1; done_pending = 1; in_xfer = 0;
                end
            end
            if (rvalid && rready) begin
                rq.push_back(rdata);
                r_left--;
                r_cur = DW'($urandom);
                if (rlast) begin
                    bursts_done++;
                    if (bursts_done == nexp) begin
                        finished = 1; done_pending = 1; in_xfer = 0;
                    end
                end
            end
            if (u_rvalid && u_rready) begin
                exp_r = (rq.size() > 0) ? rq.pop_front() : 'x;
                check("u_rdata", u_rdata, exp_r);
                check("u_rlast", u_rlast, ruser == total - 1);
                ruser++;
            end
            if (abort_wbeats > 0 && ws >= abort_wbeats) begin
                aborted = 1;
                break;
            end
        end

        if (!aborted) begin
            check("w_beats", ws, wr ? total : 0);
            check("r_beats", ruser, wr ? 0 : total);
            check("aw_count", aw_cnt, wr ? nexp : 0);
            check("ar_count", ar_cnt, wr ? 0 : nexp);
        end
    endtask

    typedef struct {
        bit     wr;
        longint addr;
        int     len;
        bit     stall;
        int     nb;
        int     len0;
        int     lenl;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int     nb, l0, ll;
        logic [255:0] outs;
        longint ra;

        tbl[0] = '{1'b1, 'h000,        599,  1'b1, 3,  255, 87};
        tbl[1] = '{1'b0, 'h3F0,        19,   1'b1, 2,  7,   11};
        tbl[2] = '{1'b1, 'h010,        0,    1'b0, 1,  0,   0};
        tbl[3] = '{1'b1, ADDR_SPACE-4, 3,    1'b1, 2,  1,   1};
        tbl[4] = '{1'b0, 'h1FE,        299,  1'b1, 3,  255, 42};
        tbl[5] = '{1'b0, 'h3FE,        0,    1'b0, 1,  0,   0};
        tbl[6] = '{1'b1, 'h3FE,        1,    1'b1, 2,  0,   0};
        tbl[7] = '{1'b0, 'h000,        4095, 1'b0, 16, 255, 255};
        tbl[8] = '{1'b1, 'h3F1,        4,    1'b1, 1,  4,   4};

        // Reset state
        idle_inputs();
        core_rst = 1;
        #1;
        outs = {cmd_ready, cmd_done, busy, u_wready, u_rvalid, u_rdata, u_rlast,
                awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
                arvalid, araddr, arlen, rready};
        check("reset_outputs", 64'(outs), 0);
        repeat (2) @(negedge core_clk);
        core_rst = 0;
        #1;
        check("ready_before_clk", cmd_ready, 0);
        @(negedge core_clk);
        #1;
        check("ready_after_clk", cmd_ready, 1);
        check("busy_idle", busy, 0);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_transfer(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].stall, 0, nb, l0, ll);
            check("tbl_nbursts", nb, tbl[i].nb);
            check("tbl_first_len", l0, tbl[i].len0);
            check("tbl_last_len", ll, tbl[i].lenl);
            $display("vec %0d wr=%0d addr=%0h len=%0d bursts=%0d first=%0d last=%0d",
                     i, tbl[i].wr, tbl[i].addr, tbl[i].len, nb, l0, ll);
        end

        // Reset in the middle of write data
        run_transfer(1'b1, 'h100, 99, 1'b1, 10, nb, l0, ll);
        #1;
        core_rst = 1;
        #1;
        outs = {cmd_ready, cmd_done, busy, u_wready, u_rvalid, u_rdata, u_rlast,
                awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
                arvalid, araddr, arlen, rready};
        check("midrst_outputs", 64'(outs), 0);
        idle_inputs();
        repeat (3) begin
            @(negedge core_clk);
            #1;
            check("midrst_no_done", cmd_done, 0);
            check("midrst_busy", busy, 0);
        end
        core_rst = 0;
        @(negedge core_clk);
        #1;
        check("postrst_ready", cmd_ready, 1);
        check("postrst_no_done", cmd_done, 0);
        run_transfer(1'b0, 'h3F0, 19, 1'b1, 0, nb, l0, ll);
        check("postrst_nbursts", nb, 2);
        $display("post-reset read bursts=%0d first=%0d last=%0d", nb, l0, ll);

        // Randomized transfers, checked against the burst model
        for (int i = 0; i < 10; i++) begin
            bit rw;
            int rl;
            rw = 1'($urandom_range(0, 1));
            rl = $urandom_range(0, 700);
            if ($urandom_range(0, 1) == 1)
                ra = longint'($urandom) % ADDR_SPACE;
            else
                ra = ((longint'($urandom) % (ADDR_SPACE / ROW_BYTES)) + 1) * ROW_BYTES
                     - 2 * longint'($urandom_range(1, 20));
            ra = ra % ADDR_SPACE;
            run_transfer(rw, ra, rl, 1'b1, 0, nb, l0, ll);
            $display("rand %0d wr=%0d addr=%0h len=%0d bursts=%0d", i, rw, ra, rl, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
